// File: rtl/manchester_rx.sv
// Manchester line decoder: recovers DATA_BITS-wide frames from an
// oversampled line, validating the sync symbol and every mid-bit transition.
module manchester_rx #(
  parameter int HALF_CYC  = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 line_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 code_err,
  output logic                 busy
);

  localparam int CW = $clog2(HALF_CYC);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] START_LOAD = CW'(HALF_CYC / 2 - 1);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYC - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 sync2;
  logic                 hist;
  logic                 mode_q;
  logic [CW-1:0]        cnt;
  logic                 phase;
  logic                 first_q;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rise_det;
  logic                 tick;
  logic                 dec_bit;

  assign rise_det = sync2 & ~hist;
  assign tick     = (cnt == '0);
  assign dec_bit  = sync2 ^ mode_q;

  // Two-flop synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Frame FSM: half-bit centre sampling, sync check, pairwise symbol decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      cnt        <= '0;
      phase      <= 1'b0;
      first_q    <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      code_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      code_err   <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (rise_det) begin
            mode_q <= mode;
            cnt    <= START_LOAD;
            phase  <= 1'b0;
            state  <= START;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            cnt <= HALF_LOAD;
            if (!phase) begin
              if (!sync2) begin
                code_err <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                phase <= 1'b1;
              end
            end else if (sync2) begin
              code_err <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              phase   <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            cnt <= HALF_LOAD;
            if (!phase) begin
              first_q <= sync2;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (first_q == sync2) begin
                code_err <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                shift <= {shift[DATA_BITS-2:0], dec_bit};
                if (bit_cnt == LAST_BIT) begin
                  // Publish directly from the shifted value so the frame
                  // completes one cycle after its final centre sample.
                  data_out   <= {shift[DATA_BITS-2:0], dec_bit};
                  data_valid <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
                end else begin
                  bit_cnt <= bit_cnt + BW'(1);
                end
              end
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_rx.sv
// Testbench for manchester_rx: directed and randomised frames driven as
// half-bit level lists, checked every cycle against a half-bit level model.
module tb_manchester_rx;

  localparam int H  = 8;
  localparam int DB = 8;
  localparam int NH = 2 * DB + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          line_in;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          code_err;
  logic          busy;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic          hv  [0:NH-1];
  int            jit [0:NH];
  logic [DB-1:0] exp_data;

  manchester_rx #(.HALF_CYC(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .mode(mode), .line_in(line_in),
    .data_out(data_out), .data_valid(data_valid),
    .code_err(code_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sync symbol 1,0 then each bit as (first, second) with second = bit ^ md.
  task automatic set_frame(input logic [DB-1:0] val, input logic md);
    hv[0] = 1'b1;
    hv[1] = 1'b0;
    for (int i = 0; i < DB; i++) begin
      hv[3+2*i] = val[DB-1-i] ^ md;
      hv[2+2*i] = ~(val[DB-1-i] ^ md);
    end
  endtask

  task automatic set_jitter(input int j);
    for (int i = 0; i <= NH; i++)
      jit[i] = (i == 0 || j == 0) ? 0 : int'($urandom_range(2 * j)) - j;
  endtask

  function automatic logic half(input int i, input int nh);
    return (i < nh) ? hv[i] : 1'b0;
  endfunction

  // Line level for cycle offset off, with jittered half-bit boundaries.
  function automatic logic level(input int nh, input int off);
    int lo, hi;
    for (int k = 0; k < nh; k++) begin
      lo = (k == 0) ? 0 : k * H + jit[k];
      hi = (k == nh - 1) ? nh * H : (k + 1) * H + jit[k+1];
      if (off >= lo && off < hi) return hv[k];
    end
    return 1'b0;
  endfunction

  // Outcome from centre-sampled halves: kind 1 = code error, 2 = good frame;
  // k is the half-bit sample index at which the outcome is decided.
  task automatic model(input int nh, input logic md, output int kind, output int k,
                       output logic [DB-1:0] d);
    logic f, s;
    kind = 2;
    k    = 2 * DB + 1;
    d    = '0;
    if (half(0, nh) !== 1'b1) begin
      kind = 1; k = 0;
    end else if (half(1, nh) !== 1'b0) begin
      kind = 1; k = 1;
    end else begin
      for (int b = 0; b < DB; b++) begin
        f = half(2 + 2 * b, nh);
        s = half(3 + 2 * b, nh);
        if (f === s) begin
          kind = 1; k = 3 + 2 * b;
          break;
        end
        d = {d[DB-2:0], s ^ md};
      end
    end
  endtask

  // Drive one frame from a negedge; offset 0 is the cycle the line first rises.
  task automatic run_frame(input string tag, input int nh, input logic md, input int gap,
                           input bit scramble, input int rst_at);
    int kind, k, ev, len;
    logic [DB-1:0] d;
    bit aborted;
    model(nh, md, kind, k, d);
    ev      = 3 + H / 2 + k * H;
    len     = ((nh * H > ev + 1) ? nh * H : ev + 1) + gap;
    aborted = 1'b0;
    mode    = md;
    for (int off = 0; off < len && !aborted; off++) begin
      if (off == rst_at) begin
        rst = 1'b1;
        line_in = 1'b0;
        #1;
        check({tag, ".rst_dout"}, 32'(data_out), 32'd0);
        check({tag, ".rst_valid"}, 32'(data_valid), 32'd0);
        check({tag, ".rst_err"}, 32'(code_err), 32'd0);
        check({tag, ".rst_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_data = '0;
        repeat (H) @(negedge clk);
        aborted = 1'b1;
      end else begin
        check($sformatf("%s.valid@%0d", tag, off), 32'(data_valid), 32'(kind == 2 && off == ev));
        check($sformatf("%s.err@%0d", tag, off), 32'(code_err), 32'(kind == 1 && off == ev));
        check($sformatf("%s.busy@%0d", tag, off), 32'(busy), 32'(off >= 3 && off < ev));
        check($sformatf("%s.dout@%0d", tag, off), 32'(data_out),
              32'((kind == 2 && off >= ev) ? d : exp_data));
        line_in = level(nh, off);
        if (scramble && off >= 3) mode = 1'($urandom);
        @(negedge clk);
      end
    end
    if (!aborted && kind == 2) exp_data = d;
  endtask

  initial begin
    logic [DB-1:0] v;
    logic md;
    int p, nh;
    rst = 1'b1;
    mode = 1'b0;
    line_in = 1'b0;
    exp_data = '0;
    set_jitter(0);
    repeat (3) @(negedge clk);
    check("reset.dout", 32'(data_out), 32'd0);
    check("reset.valid", 32'(data_valid), 32'd0);
    check("reset.err", 32'(code_err), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // IEEE 0xA5, then the identical waveform decoded as Thomas.
    set_frame(8'hA5, 1'b0);
    run_frame("ieee_a5", NH, 1'b0, 2 * H, 1'b0, -1);
    check("ieee_a5.final", 32'(data_out), 32'hA5);
    run_frame("thomas_5a", NH, 1'b1, 2 * H, 1'b0, -1);
    check("thomas_5a.final", 32'(data_out), 32'h5A);

    // 0x3C with its fourth transmitted bit sent as 11, then a clean 0x81.
    set_frame(8'h3C, 1'b0);
    hv[8] = 1'b1;
    hv[9] = 1'b1;
    run_frame("violation", 10, 1'b0, 2 * H, 1'b0, -1);
    check("violation.hold", 32'(data_out), 32'h5A);
    set_frame(8'h81, 1'b0);
    run_frame("clean_81", NH, 1'b0, 2 * H, 1'b0, -1);
    check("clean_81.final", 32'(data_out), 32'h81);

    // Bad sync: line held high well past the sync symbol.
    for (int i = 0; i < 6; i++) hv[i] = 1'b1;
    run_frame("bad_sync", 6, 1'b0, 2 * H, 1'b0, -1);

    // Back-to-back 0x00 / 0xFF, clean then with +/-3 cycle edge jitter.
    for (int j = 0; j <= 3; j += 3) begin
      set_jitter(j);
      set_frame(8'h00, 1'b0);
      run_frame($sformatf("b2b_00_j%0d", j), NH, 1'b0, 2 * H, 1'b0, -1);
      set_jitter(j);
      set_frame(8'hFF, 1'b0);
      run_frame($sformatf("b2b_ff_j%0d", j), NH, 1'b0, 2 * H, 1'b0, -1);
      check($sformatf("b2b_ff_j%0d.final", j), 32'(data_out), 32'hFF);
    end
    set_jitter(0);

    // Reset during data bit 4 of 0x55, then 0xC3.
    set_frame(8'h55, 1'b0);
    run_frame("rst_mid", NH, 1'b0, 2 * H, 1'b0, 85);
    set_frame(8'hC3, 1'b0);
    run_frame("after_rst", NH, 1'b0, 2 * H, 1'b0, -1);
    check("after_rst.final", 32'(data_out), 32'hC3);

    // Random payloads, modes, jitter and mid-frame mode toggling,
    // with some frames corrupted into a symbol violation.
    for (int r = 0; r < 10; r++) begin
      v  = DB'($urandom);
      md = 1'($urandom);
      set_jitter(int'($urandom_range(3)));
      set_frame(v, md);
      nh = NH;
      if ($urandom_range(2) == 0) begin
        p = int'($urandom_range(DB - 1));
        hv[2+2*p] = hv[3+2*p];
        nh = 4 + 2 * p;
      end
      run_frame($sformatf("rand%0d", r), nh, md, 2 * H, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
